cmd_arbiter: RTL
================

Name: cmd_arbiter

Overview:
- Sits between the command sources (UART_wrapper and the tour move translator) and cmd_proc.
- Buffers UART commands in a small FIFO and grants cmd_proc to one source at a time; tour commands take priority.
- Tracks each issued command to completion (send_resp), with a watchdog on completion.
- Sequences the BLE response byte back through UART_wrapper.

Parameters:
- DEPTH, 4: UART command FIFO entries; must be a power of 2, minimum 2.
- TMO_W, 24: watchdog counter width. Timeout occurs at 2^TMO_W-1 cycles spent in WAIT_DONE.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_UART  in  16  command from UART_wrapper
- cmd_rdy_UART  in  1  level; UART command available
- clr_UART  out  1  one-cycle pulse; consumes the UART command
- tour_cmd  in  16  command from the tour translator
- tour_vld  in  1  tour command valid
- tour_last  in  1  qualifies tour_cmd as the final move of the tour
- tour_rdy  out  1  one-cycle pulse; tour_cmd accepted
- cmd  out  16  command presented to cmd_proc
- cmd_rdy  out  1  command valid to cmd_proc
- clr_cmd_rdy  in  1  cmd_proc has taken cmd
- send_resp  in  1  cmd_proc finished the current command
- resp  out  8  response byte
- trmt  out  1  one-cycle pulse; start response transmit
- tx_done  in  1  response byte transmitted
- busy  out  1  high in any state other than IDLE
- tmo  out  1  sticky; watchdog expired since reset
- fifo_cnt  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: all outputs 0 (cmd=16'h0000, resp=8'h00); FIFO empty; state IDLE; watchdog counter 0.
- UART FIFO push:
  - Push occurs when cmd_rdy_UART=1, FIFO not full, and clr_UART was not asserted the previous cycle (prevents a double push while UART_wrapper clears its flag).
  - clr_UART pulses on the push cycle.
  - Full FIFO: no push, no clr_UART; cmd_rdy_UART stays high until space frees (backpressure, no drop).
  - Simultaneous push and pop on a full FIFO: the pop frees space and the push is allowed the same cycle; count is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESP, WAIT_TX.
- IDLE:
  - If tour_vld: latch tour_cmd and tour_last, src=TOUR, pulse tour_rdy, go to ISSUE.
  - Else if FIFO not empty: pop head into cmd, src=UART, go to ISSUE.
  - Tour wins when both sources are ready.
  - cmd is registered, so cmd_rdy rises the cycle after the grant (1-cycle grant latency).
- ISSUE: cmd_rdy=1 and cmd held stable. On clr_cmd_rdy: cmd_rdy=0 the next cycle, watchdog cleared, go to WAIT_DONE.
- WAIT_DONE:
  - Watchdog increments every cycle.
  - On send_resp go to RESP.
  - If the count reaches all-ones without send_resp: set tmo, force resp=8'hEE, go to RESP.
  - send_resp on the same cycle as expiry: send_resp wins and tmo is not set.
- RESP: one cycle.
  - resp = 8'hA5 if src=UART, or src=TOUR with tour_last=1; 8'h5A if src=TOUR with tour_last=0.
  - A timeout overrides with 8'hEE.
  - trmt pulses this cycle; go to WAIT_TX.
- WAIT_TX:
  - resp held; wait for tx_done, then go to IDLE.
  - The next grant may happen on the following cycle, so the back-to-back command gap is 1 idle cycle minimum.
- Independence of the FIFO: pushes continue in every state.
- Reset mid-operation: asynchronous return to reset values immediately; FIFO contents discarded.
- Out-of-state inputs:
  - clr_cmd_rdy outside ISSUE, send_resp outside WAIT_DONE, and tx_done outside WAIT_TX are ignored.
  - tour_vld dropping while in ISSUE has no effect, since tour_cmd is already latched.

Test Plan:
1. UART single command: cmd_UART=16'h2000 with cmd_rdy_UART -> clr_UART pulses once; cmd=16'h2000 with cmd_rdy=1 one cycle after grant. Then clr_cmd_rdy, send_resp -> resp=8'hA5, trmt one pulse; after tx_done, busy=0.
2. Priority: FIFO holds 16'h4001 and tour_vld with tour_cmd=16'h5002, tour_last=0 in the same cycle -> tour issued first; resp=8'h5A; then 16'h4001 issued with resp=8'hA5.
3. FIFO full: hold cmd_rdy_UART and supply 6 commands while cmd_proc stalls in ISSUE (DEPTH=4) -> fifo_cnt saturates at 4; no clr_UART while full. All commands issue later in order with none lost.
4. Last tour move: tour_last=1, tour_cmd=16'h3401 -> resp=8'hA5 after send_resp.
5. Watchdog (TMO_W=4): withhold send_resp after clr_cmd_rdy -> after 15 cycles tmo=1, resp=8'hEE, trmt pulses. Separately, send_resp on the expiry cycle -> resp=8'hA5 and tmo stays 0.
6. Async reset asserted in WAIT_DONE with 3 FIFO entries -> cmd_rdy=0, busy=0, fifo_cnt=0, tmo=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cmd_arbiter_if.sv
// Command arbiter bus: UART source, tour source, cmd_proc and response side.
// The slave modport is the arbiter's view; master is the surrounding system.
interface cmd_arbiter_if #(
  parameter int DEPTH = 4
);
  logic [15:0]            cmd_UART;
  logic                   cmd_rdy_UART;
  logic                   clr_UART;
  logic [15:0]            tour_cmd;
  logic                   tour_vld;
  logic                   tour_last;
  logic                   tour_rdy;
  logic [15:0]            cmd;
  logic                   cmd_rdy;
  logic                   clr_cmd_rdy;
  logic                   send_resp;
  logic [7:0]             resp;
  logic                   trmt;
  logic                   tx_done;
  logic                   busy;
  logic                   tmo;
  logic [$clog2(DEPTH):0] fifo_cnt;

  modport slave (
    input  cmd_UART, cmd_rdy_UART, tour_cmd, tour_vld, tour_last,
           clr_cmd_rdy, send_resp, tx_done,
    output clr_UART, tour_rdy, cmd, cmd_rdy, resp, trmt, busy, tmo, fifo_cnt
  );

  modport master (
    output cmd_UART, cmd_rdy_UART, tour_cmd, tour_vld, tour_last,
           clr_cmd_rdy, send_resp, tx_done,
    input  clr_UART, tour_rdy, cmd, cmd_rdy, resp, trmt, busy, tmo, fifo_cnt
  );
endinterface

// File: rtl/cmd_arbiter.sv
// Command arbiter: buffers UART commands in a small FIFO, grants cmd_proc to
// one source at a time (tour first), watches each command to completion and
// sequences the BLE response byte back out through UART_wrapper.
module cmd_arbiter #(
  parameter int DEPTH = 4,  // power of 2, at least 2
  parameter int TMO_W = 24
) (
  input logic          clk,
  input logic          rst_n,
  cmd_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Expiry is flagged one count early so the counter lands on all-ones
  // exactly when 2^TMO_W-1 cycles have been spent waiting.
  localparam logic [TMO_W-1:0] WDOG_LAST = ~(TMO_W'(1));

  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_MORE = 8'h5A;
  localparam logic [7:0] RESP_TMO  = 8'hEE;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RESP, WAIT_TX} state_t;
  typedef enum logic {SRC_UART, SRC_TOUR} src_t;

  // UART FIFO
  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             clr_q;
  logic             full, empty, push, pop;

  // Grant / completion tracking
  state_t           state;
  src_t             src;
  logic             last_q;
  logic [15:0]      cmd_q;
  logic             cmd_rdy_q, tour_rdy_q, trmt_q, busy_q, tmo_q;
  logic [7:0]       resp_q;
  logic [TMO_W-1:0] wdog;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  // A UART pop only happens from IDLE when no tour command is competing.
  assign pop   = (state == IDLE) && !bus.tour_vld && !empty;
  // Skip the cycle after a push: UART_wrapper's flag may still read high
  // while it clears. A same-cycle pop makes room on a full FIFO.
  assign push  = bus.cmd_rdy_UART && !clr_q && (!full || pop);

  // FIFO pointers, occupancy and push-history flag.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      clr_q  <= 1'b0;
    end else begin
      clr_q <= push;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write.
  // NOTE: the array is deliberately not reset; count and the pointers decide
  // which entries are valid, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.cmd_UART;
  end

  // Arbitration / completion FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      src        <= SRC_UART;
      last_q     <= 1'b0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      tour_rdy_q <= 1'b0;
      trmt_q     <= 1'b0;
      busy_q     <= 1'b0;
      tmo_q      <= 1'b0;
      resp_q     <= '0;
      wdog       <= '0;
    end else begin
      tour_rdy_q <= 1'b0;
      trmt_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tour_vld) begin
            cmd_q      <= bus.tour_cmd;
            last_q     <= bus.tour_last;
            src        <= SRC_TOUR;
            tour_rdy_q <= 1'b1;
            cmd_rdy_q  <= 1'b1;
            busy_q     <= 1'b1;
            state      <= ISSUE;
          end else if (pop) begin
            cmd_q     <= mem[rd_ptr];
            last_q    <= 1'b0;
            src       <= SRC_UART;
            cmd_rdy_q <= 1'b1;
            busy_q    <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.clr_cmd_rdy) begin
            cmd_rdy_q <= 1'b0;
            wdog      <= '0;
            state     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          wdog <= wdog + 1'b1;
          if (bus.send_resp) begin
            resp_q <= (src == SRC_UART || last_q) ? RESP_ACK : RESP_MORE;
            trmt_q <= 1'b1;
            state  <= RESP;
          end else if (wdog == WDOG_LAST) begin
            tmo_q  <= 1'b1;
            resp_q <= RESP_TMO;
            trmt_q <= 1'b1;
            state  <= RESP;
          end
        end
        RESP: begin
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (bus.tx_done) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.clr_UART = push;
  assign bus.tour_rdy = tour_rdy_q;
  assign bus.cmd      = cmd_q;
  assign bus.cmd_rdy  = cmd_rdy_q;
  assign bus.resp     = resp_q;
  assign bus.trmt     = trmt_q;
  assign bus.busy     = busy_q;
  assign bus.tmo      = tmo_q;
  assign bus.fifo_cnt = count;

endmodule
